// File: rtl/addsub_pkg.sv
// Shared add/subtract definitions: op encodings and the mode-dependent
// operand/carry selection used by the pipelined adder and any ALU reusing it.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  // Subtracting modes add the one's complement of B.
  function automatic logic invert_b(input op_e op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  // Carry into bit 0: fixed for ADD/SUB, taken from c_in for ADC/SBC.
  function automatic logic mode_carry(input op_e op, input logic c_in);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = c_in;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub; the block itself is the
// slave, the producer/consumer pair is the master.
interface pipe_addsub_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_e              op;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             v;
  logic             z;
  logic             n;

  modport master (
    output in_valid, a, b, op, c_in, out_ready,
    input  in_ready, out_valid, s, c_out, v, z, n
  );

  modport slave (
    input  in_valid, a, b, op, c_in, out_ready,
    output in_ready, out_valid, s, c_out, v, z, n
  );

endinterface

// File: rtl/pipe_addsub_add_slice.sv
// W-bit ripple-carry adder slice; also exposes the carry into the MSB so the
// last slice can derive signed overflow as c_msb ^ c_out.
module add_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o,
  output logic         c_msb_o
);

  logic carry;

  // NOTE: every output gets a default before the loop, otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    s_o     = '0;
    c_msb_o = 1'b0;
    carry   = c_i;
    for (int i = 0; i < W; i++) begin
      // NOTE: blocking assignments here on purpose -- carry must ripple
      // bit by bit within the same evaluation.
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      if (i == W - 1) c_msb_o = carry;
      carry = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: STAGES slices of WIDTH/STAGES bits each, carry
// registered between slices, operands skewed in and partial sums deskewed out.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic          clk,
  input logic          rst_n,
  pipe_addsub_if.slave bus
);

  localparam int SW = WIDTH / STAGES;

  typedef logic [WIDTH-1:0] word_t;

  // Stage registers: operands still to be consumed, partial sum, carry out.
  logic  vld_q [STAGES];
  word_t a_q   [STAGES];
  word_t b_q   [STAGES];
  word_t s_q   [STAGES];
  logic  cry_q [STAGES];
  logic  v_q, z_q, n_q;

  // Per-stage inputs (from the bus for stage 0, else from stage k-1).
  logic  vin   [STAGES];
  word_t ain   [STAGES];
  word_t bin   [STAGES];
  word_t sin   [STAGES];
  logic  cin   [STAGES];

  logic [SW-1:0] slice_s [STAGES];
  word_t         s_d     [STAGES];
  logic          cry_d   [STAGES];
  logic          cmsb    [STAGES];

  word_t b_eff;
  logic  c_mode;
  logic  advance;

  function automatic word_t put_slice(input word_t base, input logic [SW-1:0] sl,
                                      input int idx);
    word_t r;
    r = base;
    r[idx*SW +: SW] = sl;
    return r;
  endfunction

  assign b_eff   = invert_b(bus.op) ? ~bus.b : bus.b;
  assign c_mode  = mode_carry(bus.op, bus.c_in);
  assign advance = bus.out_ready | ~vld_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vin[k] = bus.in_valid;
      assign ain[k] = bus.a;
      assign bin[k] = b_eff;
      assign sin[k] = '0;
      assign cin[k] = c_mode;
    end else begin : g_body
      assign vin[k] = vld_q[k-1];
      assign ain[k] = a_q[k-1];
      assign bin[k] = b_q[k-1];
      assign sin[k] = s_q[k-1];
      assign cin[k] = cry_q[k-1];
    end

    add_slice #(.W(SW)) u_slice (
      .a_i     (ain[k][k*SW +: SW]),
      .b_i     (bin[k][k*SW +: SW]),
      .c_i     (cin[k]),
      .s_o     (slice_s[k]),
      .c_o     (cry_d[k]),
      .c_msb_o (cmsb[k])
    );

    assign s_d[k] = put_slice(sin[k], slice_s[k], k);
  end

  // Whole pipe freezes on a stall; bubbles travel with vld=0 and leave the
  // data registers (and therefore the visible result) untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: only valid bits and the visible result are reset; the inner
      // skew/deskew data is qualified by the valid chain and needs no reset.
      for (int k = 0; k < STAGES; k++) vld_q[k] <= 1'b0;
      s_q[STAGES-1]   <= '0;
      cry_q[STAGES-1] <= 1'b0;
      v_q             <= 1'b0;
      z_q             <= 1'b0;
      n_q             <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vin[k];
        if (vin[k]) begin
          a_q[k]   <= ain[k];
          b_q[k]   <= bin[k];
          s_q[k]   <= s_d[k];
          cry_q[k] <= cry_d[k];
        end
      end
      if (vin[STAGES-1]) begin
        v_q <= cry_d[STAGES-1] ^ cmsb[STAGES-1];
        z_q <= (s_d[STAGES-1] == '0);
        n_q <= s_d[STAGES-1][WIDTH-1];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.s         = s_q[STAGES-1];
  assign bus.c_out     = cry_q[STAGES-1];
  assign bus.v         = v_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, meaning pipeline depth; WIDTH SHALL be an integer multiple of STAGES, SW = WIDTH/STAGES.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operands and op present.
REQ-006 SHALL have port in_ready  output  1  block accepts an operation this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port op  input  2  mode: 00 ADD, 01 SUB, 10 ADC, 11 SBC.
REQ-010 SHALL have port c_in  input  1  carry-in, used only by ADC/SBC.
REQ-011 SHALL have port out_valid  output  1  result and flags valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port s  output  WIDTH  result.
REQ-014 SHALL have port c_out  output  1  carry out of MSB (for SUB/SBC: 1 = no borrow).
REQ-015 SHALL have ports v, z, n  output  1 each  signed overflow, result zero, result MSB.

Function
REQ-016 Arithmetic SHALL be: ADD a+b+0; SUB a+~b+1; ADC a+b+c_in; SBC a+~b+c_in; all modulo 2^WIDTH.
REQ-017 v SHALL be 1 iff both effective addends share a sign differing from s[WIDTH-1]; z SHALL be (s==0); n SHALL be s[WIDTH-1].
REQ-018 Stage k (0..STAGES-1) SHALL compute bits [k*SW +: SW] using the registered carry from stage k-1 (stage 0 uses the mode carry-in).
REQ-019 Operand slices for later stages SHALL be skew-delayed and result slices of earlier stages deskew-delayed so s, c_out and flags of one operation emerge together.
REQ-020 Latency SHALL be exactly STAGES cycles from accepted input (in_valid & in_ready) to out_valid with no stall.
REQ-021 Each stage SHALL carry a valid bit; advance = out_ready | ~out_valid; in_ready SHALL equal advance.
REQ-022 When advance=0 all pipeline registers, valid bits and outputs SHALL hold unchanged.
REQ-023 When advance=1, each stage SHALL load from its predecessor; stage 0 valid SHALL load in_valid; bubbles are not collapsed.
REQ-024 Throughput SHALL be one operation per cycle while out_ready stays 1.
REQ-025 s, c_out, v, z, n SHALL hold their last values while out_valid=0; consumers ignore them.
REQ-026 STAGES=1 SHALL give a single registered full-width adder with latency 1.

Reset
REQ-027 On rising clk with rst_n=0, all valid bits and out_valid SHALL clear to 0 and s, c_out, v, z, n SHALL clear to 0.
REQ-028 Operations in flight at reset SHALL be discarded; in_ready SHALL read 1 the cycle after reset deasserts.
REQ-029 rst_n SHALL take priority over in_valid/out_ready in the same cycle.

Structure
REQ-030 Op encodings (ADD/SUB/ADC/SBC) SHALL live in shared package addsub_pkg, reused by the ALU.
REQ-031 One sub-module add_slice (SW-bit ripple adder: a, b, c_in -> s, c_out, carry into MSB) SHALL be instantiated STAGES times via generate.
REQ-032 Only the stage valid bits, skew/deskew registers and inter-stage carries SHALL be state; no FSM beyond the valid chain.

Verification (WIDTH=32, STAGES=4)
REQ-033 ADD 0x00000001+0xFFFFFFFF, out_ready=1 -> after 4 cycles s=0x00000000, c_out=1, z=1, v=0, n=0.
REQ-034 SUB 0x80000000-0x00000001 -> s=0x7FFFFFFF, c_out=1, v=1, n=0.
REQ-035 ADC 0x7FFFFFFF+0x00000000, c_in=1 -> s=0x80000000, v=1, n=1, c_out=0.
REQ-036 Four back-to-back ADDs (1+1, 2+2, 3+3, 4+4), out_ready low for 3 cycles after first result -> results 2,4,6,8 in order, none lost or duplicated, in_ready=0 during stall.
REQ-037 rst_n=0 for one cycle with 3 operations in flight -> out_valid=0 next cycle, no stale results emerge afterwards.
REQ-038 Random 10,000 operations, all ops, random out_ready, against a reference model also with WIDTH=16/STAGES=1 and WIDTH=64/STAGES=8 -> zero mismatches.
